// File: rtl/convert_pipelined.sv
// convert_pipelined: two-stage fixed-point realignment with rounding, overflow handling and valid/ready flow control.
// Stage 1 aligns and rounds each channel; stage 2 range-checks into dout/ovf.
module convert_pipelined #(
    parameter int N_BITS_IN  = 8,
    parameter int BIN_PT_IN  = 7,
    parameter int N_BITS_OUT = 4,
    parameter int BIN_PT_OUT = 3,
    parameter int SIGNED     = 1,
    parameter int QUANT      = 0,
    parameter int OVERFLOW   = 1,
    parameter int N_CHANNELS = 1,
    parameter int CNT_BITS   = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_CHANNELS*N_BITS_IN-1:0]  din,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [N_CHANNELS*N_BITS_OUT-1:0] dout,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N_CHANNELS-1:0]            ovf,
    output logic [CNT_BITS-1:0]              ovf_count,
    input  logic                             ovf_clr
);
    localparam int D  = BIN_PT_IN - BIN_PT_OUT;
    localparam int DP = D > 0 ? D : 0;
    localparam int DN = D < 0 ? -D : 0;
    localparam int WA = (N_BITS_IN + DN > N_BITS_OUT) ? N_BITS_IN + DN : N_BITS_OUT;
    // DP extra bits keep every discarded bit visible before the right shift
    localparam int W  = WA + 2 + DP;
    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] HALF = DP > 0 ? ONE << (DP > 0 ? DP - 1 : 0) : '0;
    localparam logic [W-1:0] LOW  = DP > 1 ? HALF - ONE : '0;
    localparam logic signed [W-1:0] MAXV = SIGNED != 0 ? $signed((ONE << (N_BITS_OUT - 1)) - ONE)
                                                       : $signed((ONE << N_BITS_OUT) - ONE);
    localparam logic signed [W-1:0] MINV = SIGNED != 0 ? -$signed(ONE << (N_BITS_OUT - 1)) : '0;

    logic                             w_adv;
    logic                             w_fire;
    logic                             r_v1;
    logic                             r_v2;
    logic [N_CHANNELS*N_BITS_OUT-1:0] w_dout;
    logic [N_CHANNELS-1:0]            w_ovf;
    logic [N_CHANNELS*N_BITS_OUT-1:0] r_dout;
    logic [N_CHANNELS-1:0]            r_ovf;
    logic [CNT_BITS-1:0]              r_cnt;

    assign w_adv     = out_ready | ~r_v2;
    assign in_ready  = w_adv;
    assign out_valid = r_v2;
    assign dout      = r_dout;
    assign ovf       = r_ovf;
    assign ovf_count = r_cnt;
    assign w_fire    = r_v2 & out_ready & |r_ovf;

    genvar k;
    for (k = 0; k < N_CHANNELS; k++) begin : g_ch
        logic [N_BITS_IN-1:0]  w_x;
        logic [W-1:0]          w_xe;
        logic signed [W-1:0]   w_q;
        logic signed [W-1:0]   w_r;
        logic signed [W-1:0]   r_s1;
        logic                  w_half;
        logic                  w_below;
        logic                  w_inc;
        logic                  w_hi;
        logic                  w_lo;
        assign w_x     = din[k*N_BITS_IN +: N_BITS_IN];
        assign w_xe    = {{(W-N_BITS_IN){(SIGNED != 0) & w_x[N_BITS_IN-1]}}, w_x};
        assign w_q     = ($signed(w_xe) <<< DN) >>> DP;
        assign w_half  = |(w_xe & HALF);
        assign w_below = |(w_xe & LOW);
        // half-even only rounds up a tie when the floored LSB is odd
        assign w_inc   = QUANT == 1 ? w_half : QUANT == 2 ? w_half & (w_below | w_q[0]) : 1'b0;
        assign w_r     = w_q + $signed({{(W-1){1'b0}}, w_inc});
        always_ff @(posedge clk) begin
            if (!rst_n) r_s1 <= '0;
            else if (w_adv) r_s1 <= w_r;
        end
        assign w_hi = r_s1 > MAXV;
        assign w_lo = r_s1 < MINV;
        assign w_ovf[k] = w_hi | w_lo;
        assign w_dout[k*N_BITS_OUT +: N_BITS_OUT] =
            (OVERFLOW != 0 && w_hi) ? MAXV[N_BITS_OUT-1:0] :
            (OVERFLOW != 0 && w_lo) ? MINV[N_BITS_OUT-1:0] : r_s1[N_BITS_OUT-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_dout <= '0;
            r_ovf  <= '0;
        end else if (w_adv) begin
            r_v1   <= in_valid;
            r_v2   <= r_v1;
            r_dout <= w_dout;
            r_ovf  <= w_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || ovf_clr) r_cnt <= '0;
        else if (w_fire && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: tb/tb_convert_pipelined.sv
// tb_convert_pipelined: directed checks of several converter configurations sharing one handshake.
module tb_convert_pipelined;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic ovf_clr = 1'b0;
    logic [3:0] d4 = '0;
    logic [7:0] d8 = '0;
    logic [7:0] d8x = '0;
    logic ir_a, ir_b, ir_c, ir_d, ir_e, ir_f, ir_g;
    logic ov_a, ov_b, ov_c, ov_d, ov_e, ov_f, ov_g;
    logic [3:0] do_a, do_b, do_c, do_d, do_e;
    logic [11:0] do_f, do_g;
    logic of_a, of_b, of_c, of_d, of_e;
    logic [1:0] of_f, of_g;
    logic [15:0] c_a, c_b, c_c, c_e, c_f, c_g;
    logic [1:0] c_d;
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    convert_pipelined #(.N_BITS_IN(4), .BIN_PT_IN(4), .N_BITS_OUT(4), .BIN_PT_OUT(2), .SIGNED(0), .QUANT(0),
        .OVERFLOW(1), .N_CHANNELS(1), .CNT_BITS(16)) u_a (.clk(clk), .rst_n(rst_n), .din(d4),
        .in_valid(in_valid), .in_ready(ir_a), .dout(do_a), .out_valid(ov_a), .out_ready(out_ready),
        .ovf(of_a), .ovf_count(c_a), .ovf_clr(ovf_clr));
    convert_pipelined #(.N_BITS_IN(4), .BIN_PT_IN(4), .N_BITS_OUT(4), .BIN_PT_OUT(2), .SIGNED(0), .QUANT(1),
        .OVERFLOW(1), .N_CHANNELS(1), .CNT_BITS(16)) u_b (.clk(clk), .rst_n(rst_n), .din(d4),
        .in_valid(in_valid), .in_ready(ir_b), .dout(do_b), .out_valid(ov_b), .out_ready(out_ready),
        .ovf(of_b), .ovf_count(c_b), .ovf_clr(ovf_clr));
    convert_pipelined #(.N_BITS_IN(4), .BIN_PT_IN(4), .N_BITS_OUT(4), .BIN_PT_OUT(2), .SIGNED(0), .QUANT(2),
        .OVERFLOW(1), .N_CHANNELS(1), .CNT_BITS(16)) u_c (.clk(clk), .rst_n(rst_n), .din(d4),
        .in_valid(in_valid), .in_ready(ir_c), .dout(do_c), .out_valid(ov_c), .out_ready(out_ready),
        .ovf(of_c), .ovf_count(c_c), .ovf_clr(ovf_clr));
    convert_pipelined #(.N_BITS_IN(8), .BIN_PT_IN(4), .N_BITS_OUT(4), .BIN_PT_OUT(2), .SIGNED(1), .QUANT(0),
        .OVERFLOW(1), .N_CHANNELS(1), .CNT_BITS(2)) u_d (.clk(clk), .rst_n(rst_n), .din(d8),
        .in_valid(in_valid), .in_ready(ir_d), .dout(do_d), .out_valid(ov_d), .out_ready(out_ready),
        .ovf(of_d), .ovf_count(c_d), .ovf_clr(ovf_clr));
    convert_pipelined #(.N_BITS_IN(8), .BIN_PT_IN(4), .N_BITS_OUT(4), .BIN_PT_OUT(2), .SIGNED(1), .QUANT(0),
        .OVERFLOW(0), .N_CHANNELS(1), .CNT_BITS(16)) u_e (.clk(clk), .rst_n(rst_n), .din(d8),
        .in_valid(in_valid), .in_ready(ir_e), .dout(do_e), .out_valid(ov_e), .out_ready(out_ready),
        .ovf(of_e), .ovf_count(c_e), .ovf_clr(ovf_clr));
    convert_pipelined #(.N_BITS_IN(4), .BIN_PT_IN(4), .N_BITS_OUT(6), .BIN_PT_OUT(4), .SIGNED(1), .QUANT(0),
        .OVERFLOW(1), .N_CHANNELS(2), .CNT_BITS(16)) u_f (.clk(clk), .rst_n(rst_n), .din(d8x),
        .in_valid(in_valid), .in_ready(ir_f), .dout(do_f), .out_valid(ov_f), .out_ready(out_ready),
        .ovf(of_f), .ovf_count(c_f), .ovf_clr(ovf_clr));
    convert_pipelined #(.N_BITS_IN(4), .BIN_PT_IN(4), .N_BITS_OUT(6), .BIN_PT_OUT(4), .SIGNED(0), .QUANT(0),
        .OVERFLOW(1), .N_CHANNELS(2), .CNT_BITS(16)) u_g (.clk(clk), .rst_n(rst_n), .din(d8x),
        .in_valid(in_valid), .in_ready(ir_g), .dout(do_g), .out_valid(ov_g), .out_ready(out_ready),
        .ovf(of_g), .ovf_count(c_g), .ovf_clr(ovf_clr));

    logic [3:0]  v4 [4]  = '{4'b0010, 4'b0100, 4'b0110, 4'b1111};
    logic [7:0]  v8 [4]  = '{8'h78, 8'h80, 8'h10, 8'hFC};
    logic [7:0]  v8x [4] = '{8'h69, 8'hF7, 8'h80, 8'h1E};
    logic [3:0]  ea [4]  = '{4'h0, 4'h1, 4'h1, 4'h3};
    logic [3:0]  eb [4]  = '{4'h1, 4'h1, 4'h2, 4'h4};
    logic [3:0]  ec [4]  = '{4'h0, 4'h1, 4'h2, 4'h4};
    logic [3:0]  ed [4]  = '{4'h7, 4'h8, 4'h4, 4'hF};
    logic [3:0]  ee [4]  = '{4'hE, 4'h0, 4'h4, 4'hF};
    logic        eo [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [11:0] ef [4]  = '{12'h1B9, 12'hFC7, 12'hE00, 12'h07E};
    logic [11:0] eg [4]  = '{12'h189, 12'h3C7, 12'h200, 12'h04E};
    logic [7:0]  bp [6]  = '{8'h78, 8'h80, 8'h10, 8'hFC, 8'h20, 8'h08};
    logic [3:0]  bpd [6] = '{4'h7, 4'h8, 4'h4, 4'hF, 4'h7, 4'h2};
    logic        bpo [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p, rx;
        logic stall;
        logic [3:0] held;
        tick;
        tick;
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(ov_d), 0);
        chk("rst_dout", 32'(do_d), 0);
        chk("rst_ovf", 32'(of_d), 0);
        chk("rst_count", 32'(c_e), 0);
        chk("rst_in_ready", 32'(ir_d), 1);
        // back-to-back beats, output trails acceptance by two cycles
        for (int i = 0; i < 5; i++) begin
            in_valid = i < 4;
            d4 = i < 4 ? v4[i] : 4'h0;
            d8 = i < 4 ? v8[i] : 8'h0;
            d8x = i < 4 ? v8x[i] : 8'h0;
            tick;
            if (i == 0) chk("latency_not_early", 32'(ov_a), 0);
            else begin
                chk("out_valid", 32'(ov_a), 1);
                chk("trunc_u", 32'(do_a), 32'(ea[i-1]));
                chk("round_up", 32'(do_b), 32'(eb[i-1]));
                chk("round_even", 32'(do_c), 32'(ec[i-1]));
                chk("sat_dout", 32'(do_d), 32'(ed[i-1]));
                chk("sat_ovf", 32'(of_d), 32'(eo[i-1]));
                chk("wrap_dout", 32'(do_e), 32'(ee[i-1]));
                chk("wrap_ovf", 32'(of_e), 32'(eo[i-1]));
                chk("ext_signed_2ch", 32'(do_f), 32'(ef[i-1]));
                chk("ext_unsigned_2ch", 32'(do_g), 32'(eg[i-1]));
            end
        end
        tick;
        chk("drained", 32'(ov_a), 0);
        chk("count_sat_inst", 32'(c_d), 2);
        chk("count_wrap_inst", 32'(c_e), 2);
        // backpressure: 6 beats, out_ready low for cycles 4..8
        d4 = '0;
        d8x = '0;
        p = 0;
        rx = 0;
        stall = 1'b0;
        held = '0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 4 && c <= 8);
            in_valid = p < 6;
            d8 = p < 6 ? bp[p] : 8'h0;
            #1;
            if (c >= 4 && c <= 8) chk("bp_in_ready_low", 32'(ir_d), 0);
            if (stall) chk("bp_hold", 32'(do_d), 32'(held));
            stall = ov_d & ~out_ready;
            held = do_d;
            if (ov_d && out_ready) begin
                if (rx < 6) begin
                    chk("bp_dout", 32'(do_d), 32'(bpd[rx]));
                    chk("bp_ovf", 32'(of_d), 32'(bpo[rx]));
                end else chk("bp_extra_beat", 32'(rx), 5);
                rx++;
            end
            if (in_valid && ir_d) p++;
            tick;
        end
        chk("bp_beat_count", 32'(rx), 6);
        out_ready = 1'b1;
        in_valid = 1'b0;
        chk("cnt_saturated", 32'(c_d), 3);
        chk("cnt_wide", 32'(c_e), 5);
        ovf_clr = 1'b1;
        tick;
        ovf_clr = 1'b0;
        chk("cnt_clear", 32'(c_d), 0);
        d8 = 8'h78;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick;
        chk("cnt_5_sat2", 32'(c_d), 3);
        chk("cnt_5_wide", 32'(c_e), 5);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        chk("clr_beat_present", 32'(ov_d & of_d), 1);
        ovf_clr = 1'b1;
        tick;
        ovf_clr = 1'b0;
        chk("clr_wins_sat2", 32'(c_d), 0);
        chk("clr_wins_wide", 32'(c_e), 0);
        // reset with two beats in flight
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick;
        chk("pre_rst_count", 32'(c_d), 1);
        chk("pre_rst_valid", 32'(ov_d), 1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick;
        chk("rst_flush_valid", 32'(ov_d), 0);
        chk("rst_flush_count", 32'(c_d), 0);
        chk("rst_flush_dout", 32'(do_d), 0);
        chk("rst_flush_ovf", 32'(of_d), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("no_stale_beat", 32'(ov_d), 0);
        end
        chk("post_rst_in_ready", 32'(ir_d), 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/convert_pipelined.md
# convert_pipelined

Parametrised, pipelined fixed-point format converter and the successor to the combinational `convert` block. It realigns N_CHANNELS samples in parallel from (N_BITS_IN, BIN_PT_IN) to (N_BITS_OUT, BIN_PT_OUT). Over `convert` it adds signed sign-extension, selectable rounding, saturate/wrap overflow handling, per-channel overflow flags and a valid/ready handshake. It sits between datapath stages wherever word growth must be trimmed, for example after adders, multipliers or FFT butterflies.

## Interface
- N_BITS_IN, 8, input word width per channel.
- BIN_PT_IN, 7, input binary point (fraction bits). May be negative or larger than N_BITS_IN.
- N_BITS_OUT, 4, output word width per channel.
- BIN_PT_OUT, 3, output binary point. May be negative or larger than N_BITS_OUT.
- SIGNED, 1, 1 = two's complement in and out; 0 = unsigned.
- QUANT, 0, 0 = truncate (floor); 1 = round half up (add half LSB, floor); 2 = round half to even.
- OVERFLOW, 1, 0 = wrap (keep low N_BITS_OUT bits); 1 = saturate.
- N_CHANNELS, 1, number of parallel channels sharing one handshake.
- CNT_BITS, 16, width of the overflow event counter.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, reset. **Synchronous, active-low.**
- din, in, N_CHANNELS*N_BITS_IN, channel k occupies bits [k*N_BITS_IN +: N_BITS_IN].
- in_valid, in, 1, din is valid.
- in_ready, out, 1, block accepts din this cycle.
- dout, out, N_CHANNELS*N_BITS_OUT, converted words, same channel packing as din.
- out_valid, out, 1, dout is valid.
- out_ready, in, 1, downstream accepts dout this cycle.
- ovf, out, N_CHANNELS, per-channel overflow, aligned with dout.
- ovf_count, out, CNT_BITS, number of accepted output beats with any ovf bit set. Saturates at all-ones.
- ovf_clr, in, 1, synchronous clear of ovf_count.

## Operation
- D = BIN_PT_IN − BIN_PT_OUT is the number of LSBs discarded.
- If D ≤ 0, the input is shifted left by −D with zero fill. No rounding is applied.
- If D > 0:
  - QUANT=0: floor(x / 2^D).
  - QUANT=1: floor((x + 2^(D−1)) / 2^D).
  - QUANT=2: ties go to the result whose LSB is 0.
- D may exceed N_BITS_IN. The result is then 0 or −1 after floor, possibly adjusted by rounding.
- Extension is sign extension when SIGNED=1 and zero extension when SIGNED=0.
- The intermediate width must hold max(N_BITS_IN + max(−D,0), N_BITS_OUT) + 2 bits, so rounding carry and range checks are exact.
- Range check on the rounded value r:
  - Signed: overflow when r < −2^(N_BITS_OUT−1) or r > 2^(N_BITS_OUT−1)−1.
  - Unsigned: overflow when r > 2^N_BITS_OUT−1.
- Saturate clamps r to the nearest limit. Wrap keeps the low bits. ovf is asserted in both modes.
- Pipeline:
  - Stage 1 registers the aligned and rounded value.
  - Stage 2 registers the range-checked dout and ovf.
- Pipeline advance: `adv = out_ready | ~out_valid`.
  - in_ready = adv.
  - On adv, both stages shift and stage-1 valid loads in_valid.
  - When adv is low, all stages hold.
- ovf_count increments on each output handshake (out_valid & out_ready) with |ovf. It sticks at 2^CNT_BITS−1.
- If ovf_clr coincides with an increment, the clear wins and the count goes to 0.

## Timing
- Latency: 2 cycles from input handshake to out_valid, with no stall.
- Throughput: one beat per cycle while out_ready is high.
- Reset (rst_n low at a clock edge) sets:
  - stage valids, out_valid, dout, ovf and ovf_count all to 0;
  - in_ready to 1 from the next cycle.
- Beats in flight at reset are discarded.
- No combinational path from din to dout. in_ready depends combinationally on out_ready.
- dout and ovf hold stable while out_valid & ~out_ready.
- No beat may be lost, duplicated or reordered.

## Test plan
- **Truncate, unsigned.** IN 4/4, OUT 4/2, QUANT=0, SIGNED=0. 4'b0010 → 4'b0000; 4'b0100 → 4'b0001. Each appears 2 cycles after acceptance.
- **Rounding.** Same formats.
  - QUANT=1: 4'b0010 → 4'b0001.
  - QUANT=2: 4'b0010 → 4'b0000 and 4'b0110 → 4'b0010.
- **Overflow, signed.** IN 8/4, OUT 4/2.
  - Saturate: 8'b01111000 → 4'b0111 with ovf=1; 8'b10000000 → 4'b1000 with ovf=1.
  - Wrap: 8'b01111000 → 4'b1110 with ovf=1.
  - 8'b00010000 → 4'b0100 with ovf=0.
- **Extension.** IN 4/4, OUT 6/4. 4'b1001 → 6'b111001 when SIGNED=1, 6'b001001 when SIGNED=0. With N_CHANNELS=2, both channels convert independently with the correct packing.
- **Backpressure.** Stream 6 beats with in_valid held high. Drop out_ready for 5 cycles mid-stream. Required:
  - in_ready falls once the pipeline is full;
  - dout holds during the stall;
  - all 6 beats arrive in order, none lost or duplicated.
- **Counter and reset.**
  - CNT_BITS=2: 5 overflowing beats → ovf_count=3.
  - ovf_clr coincident with an overflowing beat → 0.
  - rst_n low with 2 beats in flight → out_valid=0 and ovf_count=0 next cycle; no stale beat emerges afterwards.
